heater_ctrl: RTL and testbench

//  Top-level sequencer for an array of NCH heater channels. Ramps channel enables on and
//  off one at a time, so supply current steps stay bounded. Holds each channel's checker
//  in clear until its pipeline has filled, then arms it. Collects errors into sticky flags
//  and a saturating counter, and can shut down all channels on the first armed error.

---
 rtl/heater_pkg.sv | 21 ++
 rtl/heater_bit_find.sv | 27 ++
 rtl/heater_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_heater_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heater_pkg.sv
// heater_pkg: state encoding, default timing constants and a counter-width helper
// shared by the heater channel sequencer.
package heater_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    FAULT     = 3'd4
  } heater_ctrl_state_t;

  localparam int HEATER_STEP_CYCLES   = 1024;
  localparam int HEATER_SETTLE_CYCLES = 512;

  // Width able to hold 0..n-1, never less than one bit.
  function automatic int heater_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/heater_bit_find.sv
// heater_bit_find: combinational lowest- or highest-set-bit finder with a valid flag.
module heater_bit_find #(
  parameter int W         = 16,
  parameter bit FIND_HIGH = 1'b0,
  parameter int IDX_W     = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     i_vec,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Priority scan: the last hit in scan order wins, so the scan direction picks low/high.
  always_comb begin
    o_valid = |i_vec;
    o_idx   = '0;
    if (FIND_HIGH) begin
      for (int i = 0; i < W; i++) begin
        o_idx = i_vec[i] ? IDX_W'(i) : o_idx;
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        o_idx = i_vec[i] ? IDX_W'(i) : o_idx;
      end
    end
  end

endmodule

// File: rtl/heater_ctrl.sv
// heater_ctrl: steps heater channel enables on/off one at a time, arms each channel's
// checker once it has settled, and logs armed errors with an optional fault shutdown.
module heater_ctrl
  import heater_pkg::*;
#(
  parameter int NCH           = 16,
  parameter int STEP_CYCLES   = HEATER_STEP_CYCLES,
  parameter int SETTLE_CYCLES = HEATER_SETTLE_CYCLES,
  parameter int ERRCNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_run_req,
  input  logic [NCH-1:0]           i_ch_mask,
  input  logic                     i_fault_stop,
  input  logic                     i_sticky_clear,
  output logic [NCH-1:0]           o_ch_enable,
  output logic [NCH-1:0]           o_ch_err_clear,
  input  logic [NCH-1:0]           i_ch_error,
  output logic [$clog2(NCH+1)-1:0] o_active_cnt,
  output logic [NCH-1:0]           o_err_sticky,
  output logic [ERRCNT_W-1:0]      o_err_count,
  output logic                     o_fault,
  output logic [2:0]               o_state
);

  localparam int IDX_W    = heater_cnt_w(NCH);
  localparam int CNT_W    = $clog2(NCH + 1);
  localparam int STEP_W   = heater_cnt_w(STEP_CYCLES);
  localparam int SETTLE_W = heater_cnt_w(SETTLE_CYCLES);

  // A single settle timer is only enough if each channel settles before the next step.
  if (SETTLE_CYCLES >= STEP_CYCLES) begin : g_bad_timing
    $error("heater_ctrl: SETTLE_CYCLES must be smaller than STEP_CYCLES");
  end

  heater_ctrl_state_t    r_state;
  heater_ctrl_state_t    w_state_nxt;
  logic [NCH-1:0]        r_mask;
  logic [NCH-1:0]        r_enable;
  logic [NCH-1:0]        r_err_clear;
  logic [NCH-1:0]        r_sticky;
  logic [ERRCNT_W-1:0]   r_err_count;
  logic                  r_fault;
  logic [CNT_W-1:0]      r_active_cnt;
  logic [STEP_W-1:0]     r_step_cnt;
  logic [SETTLE_W-1:0]   r_settle_cnt;
  logic                  r_settling;
  logic [IDX_W-1:0]      r_settle_idx;

  logic [NCH-1:0]        w_mask_nxt;
  logic [NCH-1:0]        w_enable_nxt;
  logic [NCH-1:0]        w_clear_nxt;
  logic [NCH-1:0]        w_sticky_nxt;
  logic [ERRCNT_W-1:0]   w_count_nxt;
  logic [CNT_W-1:0]      w_active_nxt;
  logic [STEP_W-1:0]     w_step_cnt_nxt;
  logic [SETTLE_W-1:0]   w_settle_cnt_nxt;
  logic                  w_settling_nxt;
  logic [IDX_W-1:0]      w_settle_idx_nxt;

  logic [NCH-1:0]        w_up_vec;
  logic                  w_up_valid;
  logic [IDX_W-1:0]      w_up_idx;
  logic                  w_dn_valid;
  logic [IDX_W-1:0]      w_dn_idx;
  logic [NCH-1:0]        w_armed_err;
  logic                  w_any_err;
  logic                  w_fault_trip;
  logic                  w_step_tick;
  logic                  w_settle_done;
  logic                  w_do_raise;
  logic                  w_do_drop;
  logic                  w_settle_end;
  logic                  w_step_restart;

  // While IDLE the live mask is used so the first channel can rise on the entry edge.
  assign w_up_vec = ((r_state == IDLE) ? i_ch_mask : r_mask) & ~r_enable;

  heater_bit_find #(.W(NCH), .FIND_HIGH(1'b0), .IDX_W(IDX_W)) u_find_up (
    .i_vec   (w_up_vec),
    .o_valid (w_up_valid),
    .o_idx   (w_up_idx)
  );

  heater_bit_find #(.W(NCH), .FIND_HIGH(1'b1), .IDX_W(IDX_W)) u_find_dn (
    .i_vec   (r_enable),
    .o_valid (w_dn_valid),
    .o_idx   (w_dn_idx)
  );

  assign w_armed_err   = i_ch_error & r_enable & ~r_err_clear;
  assign w_any_err     = |w_armed_err;
  assign w_fault_trip  = w_any_err & i_fault_stop;
  assign w_step_tick   = (r_step_cnt == STEP_W'(STEP_CYCLES - 1));
  assign w_settle_done = r_settling && (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));

  assign w_do_raise = w_up_valid &&
                      (((r_state == IDLE) && (w_state_nxt == RAMP_UP)) ||
                       ((r_state == RAMP_UP) && (w_state_nxt == RAMP_UP) &&
                        w_step_tick && !r_settling));
  assign w_do_drop  = w_dn_valid &&
                      ((((r_state == RAMP_UP) || (r_state == RUN)) && (w_state_nxt == RAMP_DOWN)) ||
                       ((r_state == RAMP_DOWN) && (w_state_nxt == RAMP_DOWN) && w_step_tick));
  assign w_settle_end = (r_state == RAMP_UP) && w_settle_done &&
                        ((w_state_nxt == RAMP_UP) || (w_state_nxt == RUN));
  assign w_step_restart = w_do_raise || w_do_drop ||
                          ((w_state_nxt != r_state) &&
                           ((w_state_nxt == RAMP_UP) || (w_state_nxt == RAMP_DOWN)));

  // sticky_clear takes priority over an error arriving in the same cycle.
  assign w_sticky_nxt = i_sticky_clear ? '0 : (r_sticky | w_armed_err);
  assign w_count_nxt  = i_sticky_clear ? '0 :
                        ((w_any_err && (r_err_count != '1)) ? (r_err_count + ERRCNT_W'(1))
                                                            : r_err_count);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_run_req) w_state_nxt = RAMP_UP;
        else           w_state_nxt = IDLE;
      end
      RAMP_UP: begin
        if (w_fault_trip)                                       w_state_nxt = FAULT;
        else if (!i_run_req)                                    w_state_nxt = RAMP_DOWN;
        else if (!w_up_valid && (!r_settling || w_settle_done)) w_state_nxt = RUN;
        else                                                    w_state_nxt = RAMP_UP;
      end
      RUN: begin
        if (w_fault_trip)    w_state_nxt = FAULT;
        else if (!i_run_req) w_state_nxt = RAMP_DOWN;
        else                 w_state_nxt = RUN;
      end
      RAMP_DOWN: begin
        if (w_fault_trip)          w_state_nxt = FAULT;
        else if (i_run_req)        w_state_nxt = RAMP_UP;
        else if (r_enable == '0)   w_state_nxt = IDLE;
        else                       w_state_nxt = RAMP_DOWN;
      end
      FAULT: begin
        if (!i_run_req) w_state_nxt = IDLE;
        else            w_state_nxt = FAULT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output logic: next values of the channel enables, clears and timers.
  always_comb begin
    w_enable_nxt     = r_enable;
    w_clear_nxt      = r_err_clear;
    w_settling_nxt   = r_settling;
    w_settle_idx_nxt = r_settle_idx;
    w_settle_cnt_nxt = r_settling ? (r_settle_cnt + SETTLE_W'(1)) : r_settle_cnt;
    w_step_cnt_nxt   = w_step_restart ? '0 :
                       (w_step_tick ? r_step_cnt : (r_step_cnt + STEP_W'(1)));
    w_mask_nxt       = ((r_state == IDLE) && (w_state_nxt == RAMP_UP)) ? i_ch_mask : r_mask;
    if (w_state_nxt == FAULT) begin
      w_enable_nxt   = '0;
      w_clear_nxt    = '1;
      w_settling_nxt = 1'b0;
    end else if (w_do_drop) begin
      // The highest enabled channel is also the one still settling, if any.
      w_enable_nxt[w_dn_idx] = 1'b0;
      w_clear_nxt[w_dn_idx]  = 1'b1;
      w_settling_nxt         = 1'b0;
    end else if (w_do_raise) begin
      w_enable_nxt[w_up_idx] = 1'b1;
      w_settling_nxt         = 1'b1;
      w_settle_cnt_nxt       = '0;
      w_settle_idx_nxt       = w_up_idx;
    end else if (w_settle_end) begin
      w_clear_nxt[r_settle_idx] = 1'b0;
      w_settling_nxt            = 1'b0;
    end else begin
      w_settling_nxt = r_settling;
    end
  end

  // Population count of the next enable vector so active_cnt tracks ch_enable exactly.
  always_comb begin
    w_active_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_active_nxt = w_active_nxt + CNT_W'(w_enable_nxt[i]);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask       <= '0;
      r_enable     <= '0;
      r_err_clear  <= '1;
      r_sticky     <= '0;
      r_err_count  <= '0;
      r_fault      <= 1'b0;
      r_active_cnt <= '0;
      r_step_cnt   <= '0;
      r_settle_cnt <= '0;
      r_settling   <= 1'b0;
      r_settle_idx <= '0;
    end else begin
      r_mask       <= w_mask_nxt;
      r_enable     <= w_enable_nxt;
      r_err_clear  <= w_clear_nxt;
      r_sticky     <= w_sticky_nxt;
      r_err_count  <= w_count_nxt;
      r_fault      <= (w_state_nxt == FAULT);
      r_active_cnt <= w_active_nxt;
      r_step_cnt   <= w_step_cnt_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_settling   <= w_settling_nxt;
      r_settle_idx <= w_settle_idx_nxt;
    end
  end

  assign o_ch_enable    = r_enable;
  assign o_ch_err_clear = r_err_clear;
  assign o_active_cnt   = r_active_cnt;
  assign o_err_sticky   = r_sticky;
  assign o_err_count    = r_err_count;
  assign o_fault        = r_fault;
  assign o_state        = r_state;

endmodule

// File: tb/tb_heater_ctrl.sv
// tb_heater_ctrl: directed stimulus pushes cycle-tagged expectations into a scoreboard;
// a negedge monitor pops and compares every entry due in the current cycle.
module tb_heater_ctrl;

  localparam int F_EN = 0, F_CL = 1, F_AC = 2, F_SK = 3, F_CT = 4, F_FT = 5, F_ST = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run_req = 1'b0;
  logic       fault_stop = 1'b0;
  logic       sticky_clear = 1'b0;
  logic [3:0] ch_mask = 4'h0;
  logic [3:0] ch_error = 4'h0;
  logic [3:0] ch_enable, ch_err_clear, err_sticky, err_count;
  logic [2:0] active_cnt, state;
  logic       fault;

  heater_ctrl #(.NCH(4), .STEP_CYCLES(16), .SETTLE_CYCLES(8), .ERRCNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_run_req      (run_req),
    .i_ch_mask      (ch_mask),
    .i_fault_stop   (fault_stop),
    .i_sticky_clear (sticky_clear),
    .o_ch_enable    (ch_enable),
    .o_ch_err_clear (ch_err_clear),
    .i_ch_error     (ch_error),
    .o_active_cnt   (active_cnt),
    .o_err_sticky   (err_sticky),
    .o_err_count    (err_count),
    .o_fault        (fault),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         fld;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   flush_req = 1'b0;

  function automatic string fname(input int f);
    case (f)
      F_EN:    return "ch_enable";
      F_CL:    return "ch_err_clear";
      F_AC:    return "active_cnt";
      F_SK:    return "err_sticky";
      F_CT:    return "err_count";
      F_FT:    return "fault";
      F_ST:    return "state";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [3:0] actual(input int f);
    case (f)
      F_EN:    return ch_enable;
      F_CL:    return ch_err_clear;
      F_AC:    return {1'b0, active_cnt};
      F_SK:    return err_sticky;
      F_CT:    return err_count;
      F_FT:    return {3'b000, fault};
      F_ST:    return {1'b0, state};
      default: return 4'h0;
    endcase
  endfunction

  task automatic expect_at(input int at, input int fld, input logic [3:0] val);
    exp_t e;
    e.at  = at;
    e.fld = fld;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_reset(input int at);
    expect_at(at, F_EN, 4'h0);
    expect_at(at, F_CL, 4'hF);
    expect_at(at, F_AC, 4'h0);
    expect_at(at, F_SK, 4'h0);
    expect_at(at, F_CT, 4'h0);
    expect_at(at, F_FT, 4'h0);
    expect_at(at, F_ST, 4'h0);
  endtask

  // Advance to just after the posedge that starts cycle c.
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation due this cycle; on flush, anything left is missed.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checks++;
        if (actual(sb[i].fld) !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", fname(sb[i].fld), cyc,
                   actual(sb[i].fld), sb[i].val);
        end
        sb.delete(i);
      end
    end
    if (flush_req) begin
      while (sb.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL unchecked_%s due=%0d got=never exp=%h", fname(sb[0].fld), sb[0].at,
                 sb[0].val);
        sb.delete(0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, a, b, c, t1, r0, s, u;

    at(3);
    reset = 1'b0;
    expect_reset(3);

    // Ramp up over mask 1011; a later mask change must not matter.
    at(4);
    ch_mask = 4'b1011;
    run_req = 1'b1;
    t0 = 5;
    expect_at(t0, F_ST, 4'd1);
    expect_at(t0, F_EN, 4'b0001);
    expect_at(t0, F_AC, 4'd1);
    expect_at(t0, F_CL, 4'hF);
    expect_at(t0 + 7, F_CL, 4'hF);
    expect_at(t0 + 8, F_CL, 4'b1110);
    expect_at(t0 + 15, F_EN, 4'b0001);
    expect_at(t0 + 16, F_EN, 4'b0011);
    expect_at(t0 + 16, F_AC, 4'd2);
    expect_at(t0 + 24, F_CL, 4'b1100);
    expect_at(t0 + 32, F_EN, 4'b1011);
    expect_at(t0 + 32, F_AC, 4'd3);
    expect_at(t0 + 39, F_ST, 4'd1);
    expect_at(t0 + 40, F_ST, 4'd2);
    expect_at(t0 + 40, F_CL, 4'b0100);
    expect_at(t0 + 40, F_AC, 4'd3);
    at(t0 + 1);
    ch_mask = 4'b1111;

    // Logged error without fault_stop, sticky_clear, clear-vs-error race, unarmed error.
    a = t0 + 42;
    at(a);
    ch_error = 4'b0010;
    expect_at(a + 1, F_SK, 4'b0010);
    expect_at(a + 1, F_CT, 4'd1);
    expect_at(a + 1, F_ST, 4'd2);
    at(a + 1);
    ch_error = 4'b0000;
    expect_at(a + 2, F_CT, 4'd1);
    at(a + 3);
    sticky_clear = 1'b1;
    expect_at(a + 4, F_SK, 4'h0);
    expect_at(a + 4, F_CT, 4'd0);
    at(a + 4);
    sticky_clear = 1'b0;
    at(a + 5);
    ch_error = 4'b0001;
    sticky_clear = 1'b1;
    expect_at(a + 6, F_SK, 4'h0);
    expect_at(a + 6, F_CT, 4'd0);
    at(a + 6);
    ch_error = 4'b0000;
    sticky_clear = 1'b0;
    at(a + 7);
    ch_error = 4'b0100;
    expect_at(a + 8, F_SK, 4'h0);
    expect_at(a + 8, F_CT, 4'd0);
    at(a + 8);
    ch_error = 4'b0000;

    // Armed error with fault_stop trips FAULT; leaving FAULT keeps the sticky flag.
    b = a + 10;
    at(b);
    fault_stop = 1'b1;
    ch_error = 4'b1000;
    expect_at(b + 1, F_ST, 4'd4);
    expect_at(b + 1, F_EN, 4'h0);
    expect_at(b + 1, F_CL, 4'hF);
    expect_at(b + 1, F_FT, 4'd1);
    expect_at(b + 1, F_SK, 4'b1000);
    expect_at(b + 1, F_AC, 4'd0);
    expect_at(b + 1, F_CT, 4'd1);
    at(b + 1);
    ch_error = 4'b0000;
    expect_at(b + 2, F_ST, 4'd4);
    at(b + 3);
    run_req = 1'b0;
    expect_at(b + 4, F_ST, 4'd0);
    expect_at(b + 4, F_FT, 4'd0);
    expect_at(b + 4, F_SK, 4'b1000);
    at(b + 4);
    fault_stop = 1'b0;

    // Full mask; errors on channel 2 while it is still settling are ignored.
    c = b + 6;
    at(c);
    ch_mask = 4'b1111;
    run_req = 1'b1;
    sticky_clear = 1'b1;
    t1 = c + 1;
    expect_at(t1, F_SK, 4'h0);
    expect_at(t1, F_EN, 4'b0001);
    expect_at(t1 + 32, F_EN, 4'b0111);
    expect_at(t1 + 34, F_SK, 4'h0);
    expect_at(t1 + 34, F_CT, 4'd0);
    expect_at(t1 + 40, F_CL, 4'b1000);
    expect_at(t1 + 40, F_SK, 4'h0);
    expect_at(t1 + 40, F_CT, 4'd0);
    expect_at(t1 + 48, F_EN, 4'hF);
    expect_at(t1 + 48, F_AC, 4'd4);
    expect_at(t1 + 55, F_ST, 4'd1);
    expect_at(t1 + 56, F_ST, 4'd2);
    expect_at(t1 + 56, F_CL, 4'h0);
    at(t1);
    sticky_clear = 1'b0;
    at(t1 + 32);
    ch_error = 4'b0100;
    at(t1 + 39);
    ch_error = 4'b0000;

    // Ramp down two steps, then resume ramp up with the remaining set kept.
    at(t1 + 58);
    run_req = 1'b0;
    r0 = t1 + 59;
    expect_at(r0, F_ST, 4'd3);
    expect_at(r0, F_EN, 4'b0111);
    expect_at(r0, F_CL, 4'b1000);
    expect_at(r0, F_AC, 4'd3);
    expect_at(r0 + 15, F_EN, 4'b0111);
    expect_at(r0 + 16, F_EN, 4'b0011);
    expect_at(r0 + 16, F_CL, 4'b1100);
    expect_at(r0 + 16, F_AC, 4'd2);
    expect_at(r0 + 20, F_ST, 4'd1);
    expect_at(r0 + 20, F_EN, 4'b0011);
    expect_at(r0 + 35, F_EN, 4'b0011);
    expect_at(r0 + 36, F_EN, 4'b0111);
    expect_at(r0 + 36, F_AC, 4'd3);
    expect_at(r0 + 44, F_CL, 4'b1000);
    expect_at(r0 + 44, F_ST, 4'd1);
    expect_at(r0 + 52, F_EN, 4'hF);
    expect_at(r0 + 60, F_ST, 4'd2);
    expect_at(r0 + 60, F_CL, 4'h0);
    expect_at(r0 + 60, F_AC, 4'd4);
    at(r0 + 19);
    run_req = 1'b1;

    // Error counter saturation over 20 consecutive armed-error cycles.
    s = r0 + 62;
    at(s);
    ch_error = 4'b0001;
    expect_at(s + 5, F_CT, 4'd5);
    expect_at(s + 15, F_CT, 4'hF);
    expect_at(s + 20, F_CT, 4'hF);
    expect_at(s + 20, F_SK, 4'b0001);
    expect_at(s + 20, F_ST, 4'd2);
    expect_at(s + 21, F_CT, 4'hF);
    at(s + 20);
    ch_error = 4'b0000;

    // Reset in the middle of a ramp-up.
    u = s + 23;
    at(u);
    run_req = 1'b0;
    expect_at(u + 1, F_ST, 4'd3);
    expect_at(u + 1, F_EN, 4'b0111);
    at(u + 1);
    run_req = 1'b1;
    expect_at(u + 2, F_ST, 4'd1);
    at(u + 5);
    reset = 1'b1;
    expect_reset(u + 6);
    at(u + 6);
    reset = 1'b0;
    run_req = 1'b0;
    expect_at(u + 7, F_ST, 4'd0);

    // Empty mask goes straight through to RUN, then back down to IDLE.
    at(u + 7);
    ch_mask = 4'b0000;
    run_req = 1'b1;
    expect_at(u + 8, F_ST, 4'd1);
    expect_at(u + 8, F_EN, 4'h0);
    expect_at(u + 9, F_ST, 4'd2);
    expect_at(u + 9, F_AC, 4'd0);
    at(u + 9);
    run_req = 1'b0;
    expect_at(u + 10, F_ST, 4'd3);
    expect_at(u + 11, F_ST, 4'd0);

    at(u + 14);
    flush_req = 1'b1;
    at(u + 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
